// File: rtl/ro_freq_meter.sv
// ro_freq_meter: multi-channel ring-oscillator frequency meter.
// One ring at a time is enabled, allowed to settle, and its synchronised
// tap edges are counted over a programmable gate window. The result is
// held for parallel read or MSB-first serial shift-out.
// Optional feature: define RO_METER_SATURATE_EN to make the counter
// saturate with a sticky overflow flag; otherwise it wraps and ovf_o is 0.
module ro_freq_meter #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 12,
  parameter int SETTLE_CYC = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [CH_W-1:0]     chan_sel_i,
  input  logic [GATE_W-1:0]   gate_len_i,
  input  logic [CHANNELS-1:0] ring_tap_i,
  output logic [CHANNELS-1:0] ring_ena_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                ovf_o,
  input  logic                shift_i,
  output logic                sout_o
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [CH_W-1:0]     ch_q;
  logic [GATE_W-1:0]   gate_q;
  logic [TMR_W-1:0]    tmr_q;
  logic [CHANNELS-1:0] ring_ena_q;
  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    count_q;
  logic                ovf_q;
  logic                sync1_q, sync2_q, sync3_q;

  logic [CH_W-1:0]     ch_d;
  logic [CHANNELS-1:0] ena_d;
  logic                tap_sel_s;
  logic                edge_s;
  logic                start_ok_s;
  logic [GATE_W-1:0]   gate_m1_s;
  logic [CNT_W-1:0]    count_d;
  logic                sat_hit_s;

  // Channel decode (out-of-range -> channel 0), one-hot enable and tap mux.
  always_comb begin
    ch_d      = ({1'b0, chan_sel_i} >= CH_LIM) ? {CH_W{1'b0}} : chan_sel_i;
    ena_d     = {CHANNELS{1'b0}};
    tap_sel_s = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_d == CH_W'(i)) begin
        ena_d[i] = 1'b1;
      end
      if (ch_q == CH_W'(i)) begin
        tap_sel_s = ring_tap_i[i];
      end
    end
    edge_s     = sync2_q & ~sync3_q;
    start_ok_s = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // gate_len of 0 wraps to all-ones, i.e. a 2^GATE_W cycle window.
    gate_m1_s  = gate_q - GATE_W'(1);
  end

  // Next counter value: saturating or wrapping depending on build option.
  always_comb begin
`ifdef RO_METER_SATURATE_EN
    if (count_q == {CNT_W{1'b1}}) begin
      count_d   = count_q;
      sat_hit_s = 1'b1;
    end else begin
      count_d   = count_q + CNT_W'(1);
      sat_hit_s = 1'b0;
    end
`else
    count_d   = count_q + CNT_W'(1);
    sat_hit_s = 1'b0;
`endif
  end

  // Free-running synchroniser plus edge-detect stage on the selected tap.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= tap_sel_s;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Measurement FSM with registered outputs, counter and shift register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      ch_q       <= {CH_W{1'b0}};
      gate_q     <= {GATE_W{1'b0}};
      tmr_q      <= {TMR_W{1'b0}};
      ring_ena_q <= {CHANNELS{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
    end else if (start_ok_s) begin
      // Start has priority over shift in DONE.
      state_q    <= ST_SETTLE;
      ch_q       <= ch_d;
      gate_q     <= gate_len_i;
      tmr_q      <= TMR_W'(SETTLE_CYC);
      ring_ena_q <= ena_d;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      count_q    <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_SETTLE: begin
          if (tmr_q == {TMR_W{1'b0}}) begin
            state_q <= ST_GATE;
            tmr_q   <= TMR_W'(gate_m1_s);
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_GATE: begin
          if (edge_s) begin
            count_q <= count_d;
            ovf_q   <= ovf_q | sat_hit_s;
          end
          if (tmr_q == {TMR_W{1'b0}}) begin
            state_q    <= ST_DONE;
            ring_ena_q <= {CHANNELS{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_DONE: begin
          if (shift_i) begin
            count_q <= count_q << 1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ring_ena_o = ring_ena_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;
  assign sout_o     = count_q[CNT_W-1];

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: randomized bench for ro_freq_meter. Taps are square
// waves driven on the falling clock edge; every tap sample taken at a rising
// edge is logged, and the expected count is the number of tap rising edges
// that become visible (3-clock latency) inside the gate window.
module tb_ro_freq_meter;

  localparam int CHN  = 3;
  localparam int CW   = 8;
  localparam int GW   = 10;
  localparam int SC   = 8;
  localparam int HMSK = 131071;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     chan_sel;
  logic [GW-1:0]  gate_len;
  logic [CHN-1:0] ring_tap = '0;
  logic [CHN-1:0] ring_ena;
  logic           busy, done, ovf, shift, sout;
  logic [CW-1:0]  count;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int hp [CHN];
  int ph [CHN] = '{default: 0};
  logic [CHN-1:0] hist [0:HMSK];

  ro_freq_meter #(.CHANNELS(CHN), .CNT_W(CW), .GATE_W(GW), .SETTLE_CYC(SC)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .chan_sel_i(chan_sel),
    .gate_len_i(gate_len), .ring_tap_i(ring_tap), .ring_ena_o(ring_ena),
    .busy_o(busy), .done_o(done), .count_o(count), .ovf_o(ovf),
    .shift_i(shift), .sout_o(sout)
  );

  always #5 clk = ~clk;

  // Log the tap value seen at each rising edge, indexed by edge number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    hist[(cyc + 1) & HMSK] <= ring_tap;
  end

  // Square-wave ring taps, half-period hp[c] clocks, changing on falling edges.
  always @(negedge clk) begin
    for (int c = 0; c < CHN; c++) begin
      ph[c] = ph[c] + 1;
      if (ph[c] >= hp[c]) begin
        ph[c] = 0;
        ring_tap[c] = ~ring_tap[c];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Rising tap edges visible (tap sampled 2 and 3 edges earlier) at gate edges.
  function automatic int model_edges(int e0, int n, int ch);
    int e = 0;
    for (int t = e0 + SC + 2; t <= e0 + SC + n + 1; t++) begin
      if (hist[(t - 2) & HMSK][ch] && !hist[(t - 3) & HMSK][ch]) e++;
    end
    return e;
  endfunction

  task automatic run(input int sel, input int gl, input bit mid_start,
                     input bit keep_shift, input bit do_shift);
    int n, ch, e0, edges, exp_ovf;
    bit found;
    logic [CW-1:0] ec;
    n  = (gl == 0) ? (1 << GW) : gl;
    ch = (sel >= CHN) ? 0 : sel;
    @(negedge clk);
    chan_sel = 2'(sel);
    gate_len = GW'(gl);
    start    = 1'b1;
    shift    = keep_shift;
    @(negedge clk);
    start = 1'b0;
    e0    = cyc;
    check_val("busy_run", 32'(busy), 32'd1);
    check_val("done_clr", 32'(done), 32'd0);
    check_val("count_clr", 32'(count), 32'd0);
    check_val("ena_run", 32'(ring_ena), 32'(1 << ch));
    found = 1'b0;
    for (int k = 1; k <= SC + n + 20; k++) begin
      @(negedge clk);
      start = (mid_start && n > 20 && k == SC + 10);
      if (done) begin
        found = 1'b1;
        start = 1'b0;
        shift = 1'b0;
        break;
      end
    end
    if (!found) begin
      check_val("done_timeout", 32'd0, 32'd1);
      shift = 1'b0;
    end else begin
      check_val("done_lat", 32'(cyc - e0), 32'(SC + n + 1));
    end
    edges = model_edges(e0, n, ch);
`ifdef RO_METER_SATURATE_EN
    ec      = (edges > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(edges);
    exp_ovf = (edges > (1 << CW) - 1) ? 1 : 0;
`else
    ec      = CW'(edges % (1 << CW));
    exp_ovf = 0;
`endif
    check_val("count", 32'(count), 32'(ec));
    check_val("ovf", 32'(ovf), 32'(exp_ovf));
    check_val("busy_done", 32'(busy), 32'd0);
    check_val("ena_done", 32'(ring_ena), 32'd0);
    if (do_shift) begin
      shift = 1'b1;
      for (int i = 0; i < CW; i++) begin
        check_val("sout", 32'(sout), 32'(ec[CW-1-i]));
        @(negedge clk);
      end
      @(negedge clk);
      shift = 1'b0;
      check_val("count_shifted", 32'(count), 32'd0);
    end
  endtask

  initial begin
    for (int c = 0; c < CHN; c++) hp[c] = 3;
    reset = 1'b1; start = 1'b0; shift = 1'b0; chan_sel = 2'd0; gate_len = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ena", 32'(ring_ena), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    check_val("rst_sout", 32'(sout), 32'd0);
    reset = 1'b0;
    // Shift outside DONE must be ignored.
    shift = 1'b1;
    repeat (2) @(negedge clk);
    shift = 1'b0;
    check_val("idle_done", 32'(done), 32'd0);

    hp[1] = 5;
    run(1, 100, 1'b0, 1'b0, 1'b1);
    run(3, 40, 1'b0, 1'b0, 1'b0);
    hp[2] = 2;
    run(2, 0, 1'b0, 1'b1, 1'b0);
    hp[0] = 1;
    run(0, 800, 1'b1, 1'b1, 1'b1);

    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < CHN; c++) hp[c] = $urandom_range(1, 6);
      run($urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 1023),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the gate window aborts the run.
    @(negedge clk);
    chan_sel = 2'd1; gate_len = GW'(100); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SC + 1 + 50) @(negedge clk);
    check_val("midgate_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_ena", 32'(ring_ena), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_count", 32'(count), 32'd0);
    reset = 1'b0;
    run(2, 60, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
